// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-forwarding producer: tracks EX/MEM/WB destination info,
// builds per-byte forwarding selects and handles load-use stall, flush and freeze.

module fwd_byte_sel #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              use_src,
    input  logic [REG_AW-1:0] src,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_we,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_we,
    output logic [1:0]        sel
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    logic live;
    assign live = use_src && (src != ZR);

    // MEM wins over WB per byte, so a word may mix 01 and 10 codes.
    always_comb begin
        sel = 2'b00;
        if (live && mem_wr && mem_we && (mem_dst == src))
            sel = 2'b01;
        else if (live && wb_wr && wb_we && (wb_dst == src))
            sel = 2'b10;
    end
endmodule

module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [3:0]        id_byte_we,
    input  logic              id_is_load,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [7:0]        A_in_sel,
    output logic [7:0]        B_in_sel,
    output logic              stall_out,
    output logic              ex_bubble
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [3:0]        byte_we;
    } slot_t;

    slot_t             ex, mem, wb;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rs, ex_rt;
    logic              ex_uses_rs, ex_uses_rt;

    function automatic logic writes(slot_t s);
        return s.valid && (s.byte_we != 4'b0000) && (s.dst != ZR);
    endfunction

    logic ex_wr, mem_wr, wb_wr, hazard;
    assign ex_wr  = writes(ex);
    assign mem_wr = writes(mem);
    assign wb_wr  = writes(wb);

    // ex_wr already excludes the zero register, so a match here is never $0.
    assign hazard = id_valid && ex_wr && ex_is_load &&
                    ((id_uses_rs && (id_rs == ex.dst)) ||
                     (id_uses_rt && (id_rt == ex.dst)));
    assign stall_out = hazard && !flush_in && !stall_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex         <= '0;
            mem        <= '0;
            wb         <= '0;
            ex_is_load <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
            ex_bubble  <= 1'b0;
        end else if (!stall_in) begin
            mem <= ex;
            wb  <= mem;
            if (flush_in || hazard) begin
                ex         <= '0;
                ex_is_load <= 1'b0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_uses_rs <= 1'b0;
                ex_uses_rt <= 1'b0;
                ex_bubble  <= 1'b1;
            end else begin
                ex         <= '{valid: id_valid, dst: id_dst, byte_we: id_byte_we};
                ex_is_load <= id_is_load;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_uses_rs <= id_uses_rs;
                ex_uses_rt <= id_uses_rt;
                ex_bubble  <= 1'b0;
            end
        end
    end

    logic [3:0][1:0] a_sel, b_sel;

    for (genvar k = 0; k < 4; k++) begin : g_byte
        fwd_byte_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_a (
            .use_src (ex.valid && ex_uses_rs),
            .src     (ex_rs),
            .mem_wr  (mem_wr),
            .mem_dst (mem.dst),
            .mem_we  (mem.byte_we[k]),
            .wb_wr   (wb_wr),
            .wb_dst  (wb.dst),
            .wb_we   (wb.byte_we[k]),
            .sel     (a_sel[k])
        );
        fwd_byte_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_b (
            .use_src (ex.valid && ex_uses_rt),
            .src     (ex_rt),
            .mem_wr  (mem_wr),
            .mem_dst (mem.dst),
            .mem_we  (mem.byte_we[k]),
            .wb_wr   (wb_wr),
            .wb_dst  (wb.dst),
            .wb_we   (wb.byte_we[k]),
            .sel     (b_sel[k])
        );
    end

    assign A_in_sel = a_sel;
    assign B_in_sel = b_sel;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from an instruction-level pipeline model.

module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [3:0] id_byte_we = '0;
    logic       id_is_load = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
    logic [7:0] A_in_sel, B_in_sel;
    logic       stall_out, ex_bubble;

    fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_byte_we(id_byte_we), .id_is_load(id_is_load), .stall_in(stall_in),
        .flush_in(flush_in), .A_in_sel(A_in_sel), .B_in_sel(B_in_sel),
        .stall_out(stall_out), .ex_bubble(ex_bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int dst; bit [3:0] we; bit ld;
    } instr_t;
    typedef struct {
        logic [7:0] a; logic [7:0] b; logic st; logic bb;
    } exp_t;

    // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    instr_t pipe[3];
    instr_t cur_id;
    bit     cur_stall, cur_flush, bub, last_stall;
    exp_t   q[$];
    int     n_cmp = 0, n_bad = 0;
    instr_t NOP;

    function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt, int dst,
                                  bit [3:0] we, bit ld);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.dst = dst; i.we = we; i.ld = ld;
        return i;
    endfunction

    function automatic bit wr(instr_t s);
        return s.v && (s.we != 4'b0) && (s.dst != 0);
    endfunction

    // Youngest older producer of the register that writes this byte.
    function automatic logic [1:0] byte_src(int r, bit use_it, int k);
        if (!pipe[0].v || !use_it || r == 0) return 2'b00;
        for (int st = 1; st <= 2; st++)
            if (wr(pipe[st]) && pipe[st].dst == r && pipe[st].we[k]) return 2'(st);
        return 2'b00;
    endfunction

    function automatic bit hazard();
        return cur_id.v && wr(pipe[0]) && pipe[0].ld &&
               ((cur_id.urs && cur_id.rs == pipe[0].dst) ||
                (cur_id.urt && cur_id.rt == pipe[0].dst));
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.a[2*k +: 2] = byte_src(pipe[0].rs, pipe[0].urs, k);
            e.b[2*k +: 2] = byte_src(pipe[0].rt, pipe[0].urt, k);
        end
        e.st = hazard() && !cur_flush && !cur_stall;
        e.bb = bub;
        return e;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = NOP;
        bub = 1'b0;
    endtask

    task automatic model_edge();
        if (cur_stall) return;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (cur_flush || hazard()) begin
            pipe[0] = NOP;
            bub = 1'b1;
        end else begin
            pipe[0] = cur_id;
            bub = 1'b0;
        end
        if (wr(pipe[1]) && pipe[1].ld && pipe[0].v &&
            ((pipe[0].urs && pipe[0].rs == pipe[1].dst) ||
             (pipe[0].urt && pipe[0].rt == pipe[1].dst))) begin
            n_bad++;
            $display("FAIL load_in_mem_feeds_ex: reg %0d at %0t", pipe[1].dst, $time);
        end
    endtask

    task automatic drive(instr_t i, bit st, bit fl);
        cur_id = i; cur_stall = st; cur_flush = fl;
        id_valid = i.v; id_rs = 5'(i.rs); id_rt = 5'(i.rt);
        id_uses_rs = i.urs; id_uses_rt = i.urt; id_dst = 5'(i.dst);
        id_byte_we = i.we; id_is_load = i.ld; stall_in = st; flush_in = fl;
    endtask

    task automatic step(instr_t i, bit st, bit fl);
        exp_t e;
        bit   r;
        @(posedge clk);
        r = rst_n;
        #1;
        if (r) model_edge();
        drive(i, st, fl);
        e = expect_now();
        last_stall = e.st;
        q.push_back(e);
    endtask

    task automatic release_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(NOP, 0, 0);
        e = expect_now();
        last_stall = e.st;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 3; n++) step(NOP, 0, 0);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_A"}, A_in_sel, 8'h00);
        chk({nm, "_B"}, B_in_sel, 8'h00);
        chk({nm, "_stall"}, 8'(stall_out), 8'h00);
        chk({nm, "_bubble"}, 8'(ex_bubble), 8'h00);
    endtask

    function automatic instr_t rnd_instr();
        instr_t i;
        bit [3:0] we;
        case ($urandom_range(0, 5))
            0: we = 4'h0;
            1: we = 4'hC;
            2: we = 4'h3;
            3: we = 4'(1 << $urandom_range(0, 3));
            4: we = 4'($urandom);
            default: we = 4'hF;
        endcase
        i = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), we, $urandom_range(0, 2) == 0);
        return i;
    endfunction

    // Scoreboard monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_A_in_sel", A_in_sel, e.a);
                chk("sb_B_in_sel", B_in_sel, e.b);
                chk("sb_stall_out", 8'(stall_out), 8'(e.st));
                chk("sb_ex_bubble", 8'(ex_bubble), 8'(e.bb));
            end
        end
    end

    initial begin
        NOP = mk(0, 0, 0, 0, 0, 0, 4'h0, 0);
        model_reset();
        drive(NOP, 0, 0);
        #2;
        chk_zero("reset");
        release_reset();

        // ALU back-to-back
        step(mk(1, 1, 2, 1, 1, 3, 4'hF, 0), 0, 0);
        step(mk(1, 3, 7, 1, 1, 8, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("b2b_A", A_in_sel, 8'h55);
        chk("b2b_B", B_in_sel, 8'h00);
        chk("b2b_stall", 8'(stall_out), 8'h00);
        drain();

        // distance-2, then MEM priority over WB
        step(mk(1, 1, 2, 1, 1, 4, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        step(mk(1, 9, 4, 1, 1, 10, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("dist2_B", B_in_sel, 8'hAA);
        step(mk(1, 1, 2, 1, 1, 4, 4'hF, 0), 0, 0);
        step(mk(1, 1, 2, 1, 1, 4, 4'hF, 0), 0, 0);
        step(mk(1, 9, 4, 1, 1, 10, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("mem_prio_B", B_in_sel, 8'h55);
        drain();

        // load-use: one stall, one bubble, then WB forward
        step(mk(1, 1, 2, 1, 0, 5, 4'hF, 1), 0, 0);
        step(mk(1, 5, 2, 1, 1, 11, 4'hF, 0), 0, 0);
        @(negedge clk);
        chk("lu_stall", 8'(stall_out), 8'h01);
        step(mk(1, 5, 2, 1, 1, 11, 4'hF, 0), 0, 0);
        @(negedge clk);
        chk("lu_stall_clear", 8'(stall_out), 8'h00);
        chk("lu_bubble", 8'(ex_bubble), 8'h01);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("lu_A", A_in_sel, 8'hAA);
        drain();

        // partial writes: upper bytes from WB, lower from MEM
        step(mk(1, 1, 2, 0, 0, 6, 4'hC, 1), 0, 0);
        step(mk(1, 1, 2, 0, 0, 6, 4'h3, 0), 0, 0);
        step(mk(1, 6, 2, 1, 0, 12, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("partial_A", A_in_sel, 8'hA5);
        drain();

        // zero register
        step(mk(1, 1, 2, 1, 1, 0, 4'hF, 0), 0, 0);
        step(mk(1, 0, 0, 1, 1, 13, 4'hF, 0), 0, 0);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("zero_A", A_in_sel, 8'h00);
        chk("zero_B", B_in_sel, 8'h00);
        step(mk(1, 1, 2, 1, 1, 0, 4'hF, 1), 0, 0);
        step(mk(1, 0, 0, 1, 1, 13, 4'hF, 0), 0, 0);
        @(negedge clk);
        chk("zero_ld_stall", 8'(stall_out), 8'h00);
        drain();

        // flush beats a pending load-use
        step(mk(1, 1, 2, 1, 0, 5, 4'hF, 1), 0, 0);
        step(mk(1, 5, 2, 1, 1, 11, 4'hF, 0), 0, 1);
        @(negedge clk);
        chk("flush_stall", 8'(stall_out), 8'h00);
        step(NOP, 0, 0);
        @(negedge clk);
        chk("flush_bubble", 8'(ex_bubble), 8'h01);
        drain();

        // freeze for 3 cycles, then reset while frozen
        step(mk(1, 1, 2, 1, 1, 3, 4'hF, 0), 0, 0);
        step(mk(1, 3, 7, 1, 1, 8, 4'hF, 0), 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(NOP, 1, 0);
            @(negedge clk);
            chk("freeze_A", A_in_sel, 8'h55);
        end
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_freeze");
        release_reset();

        // reset while a load-use stall is asserted
        step(mk(1, 1, 2, 1, 0, 5, 4'hF, 1), 0, 0);
        step(mk(1, 5, 2, 1, 1, 11, 4'hF, 0), 0, 0);
        @(negedge clk);
        chk("rst_lu_pre", 8'(stall_out), 8'h01);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_lu");
        release_reset();

        // randomized traffic; ID holds while stalled, flush holds while frozen
        for (int c = 0; c < 600; c++) begin
            instr_t i;
            bit st, fl;
            if (cur_stall) begin
                i = cur_id;
                fl = cur_flush;
            end else if (last_stall) begin
                i = cur_id;
                fl = ($urandom_range(0, 9) == 0);
            end else begin
                i = rnd_instr();
                fl = ($urandom_range(0, 9) == 0);
            end
            st = ($urandom_range(0, 6) == 0);
            step(i, st, fl);
        end
        drain();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
